rvv_backend_retire_wb: RTL and testbench
========================================

Name: rvv_backend_retire_wb

Overview:
- Retire/writeback stage directly downstream of the ROB.
- Accepts up to NUM_RT uops per cycle in program order from the ROB retire handshake.
- Resolves same-cycle byte overlaps between uops that target the same vector register, then registers VRF writes, a single XRF write, and the vxsat update.
- Sequences the trap acknowledge back to the scalar core.

Parameters:
- NUM_RT, 4, retire lanes per cycle; lane 0 is the oldest.
- VLEN, 128, vector register width in bits.
- VLENB, 16, VLEN/8, byte-strobe width.
- XLEN, 32, scalar writeback width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_valid_rob2rt  in  NUM_RT  per-lane uop valid from ROB.
- rd_ready_rt2rob  out  NUM_RT  per-lane accept.
- rt_w_valid  in  NUM_RT  uop writes a destination.
- rt_w_type  in  NUM_RT  0 = VRF, 1 = XRF.
- rt_w_index  in  NUM_RT*5  destination register.
- rt_w_data  in  NUM_RT*VLEN  result data; XRF uses bits XLEN-1:0.
- rt_vd_strobe  in  NUM_RT*VLENB  byte enable (1 = byte written).
- rt_vsaturate  in  NUM_RT*VLENB  per-byte saturation flags.
- rt_trap_flag  in  NUM_RT  uop raised a trap.
- rt2vrf_wr_valid  out  NUM_RT  registered VRF write enables; the VRF always accepts.
- rt2vrf_wr_index  out  NUM_RT*5  VRF write index.
- rt2vrf_wr_data  out  NUM_RT*VLEN  VRF write data.
- rt2vrf_wr_strobe  out  NUM_RT*VLENB  VRF byte enables after overlap resolution.
- rt2xrf_valid  out  1  scalar write request.
- rt2xrf_index  out  5  scalar destination.
- rt2xrf_data  out  XLEN  scalar data.
- xrf_ready_xrf2rt  in  1  scalar writeback accept.
- rt2vcsr_vxsat_valid  out  1  one-cycle pulse: set vxsat.
- trap_done_rvv2rvs  out  1  one-cycle pulse: trap drain complete.

Behaviour:
- Reset: every output 0, FSM in IDLE, XRF holding register empty. rd_ready is also 0 in the reset cycle.
- Accept rule: lane i is accepted when rd_valid[i] is high and all of the following hold:
  - lane i-1 was accepted (lane 0 has no such condition);
  - FSM is IDLE;
  - no lane j<i accepted this cycle carries trap_flag;
  - if lane i is XRF with w_valid, then no earlier accepted lane this cycle is an XRF write, and the XRF holding register is empty or is being accepted this cycle (xrf_ready high).
- rd_ready[i] equals the accept condition for lane i. It never depends on later lanes, so accepted lanes are always a contiguous prefix.
- VRF path, latency 1:
  - An accepted lane with w_valid, w_type=0 and no trap_flag drives rt2vrf_wr_valid[i] high in the next cycle, with index and data passed through.
  - strobe[i] = vd_strobe[i] & ~(OR of vd_strobe[j] over accepted VRF lanes j>i with the same index). The younger uop wins each overlapping byte.
  - A lane whose resolved strobe is all-zero still asserts wr_valid, with a zero strobe.
- XRF path:
  - An accepted XRF lane loads the holding register, so rt2xrf_valid rises in the next cycle.
  - rt2xrf_valid holds, with data and index stable, until xrf_ready is high; it clears in the cycle after that handshake unless a new XRF write loads the register in that same cycle.
- Trapped uop: accepted, but produces no VRF or XRF write and no vxsat contribution.
- vxsat: if any accepted, non-trapped lane with w_valid has a nonzero (vsaturate & vd_strobe), rt2vcsr_vxsat_valid pulses high in the next cycle.
- FSM:
  - IDLE -> TRAP_DRAIN when a lane with trap_flag is accepted.
  - TRAP_DRAIN: all rd_ready are 0. It exits when the XRF holding register is empty or being accepted that cycle. On exit, trap_done_rvv2rvs pulses for 1 cycle and the FSM returns to IDLE.
  - Minimum time in TRAP_DRAIN is 1 cycle; with no XRF write pending, trap_done is high exactly 2 cycles after the trap accept.
- rst asserted mid-operation: pending XRF write, FSM state, and registered VRF and vxsat pulses are all discarded. Outputs are 0 from the next cycle.
- Assertions:
  - rd_ready must be a contiguous prefix.
  - rt2xrf_data and rt2xrf_index stay stable while rt2xrf_valid is high and xrf_ready is low.

Test Plan:
- 4 valid VRF uops with indices 1, 2, 3, 4, full strobes -> rd_ready=4'b1111; next cycle wr_valid=4'b1111 with data and index matching.
- Lane0 idx 5 strobe 16'h00FF, lane1 idx 5 strobe 16'h0FF0 -> output strobe[0]=16'h000F, strobe[1]=16'h0FF0.
- Lanes 0 and 2 are XRF, xrf_ready=1 -> rd_ready=4'b0011; lane 2 is accepted the next cycle; rt2xrf_valid holds while xrf_ready=0 for 3 cycles.
- Lane1 trap_flag=1, lanes 0-3 valid, no XRF pending -> rd_ready=4'b0011; next cycle wr_valid=4'b0001, rd_ready=0; trap_done pulses 2 cycles after the accept.
- Lane2 vsaturate=16'h0001 with strobe 16'h0001 -> vxsat_valid pulses 1 cycle later; the same input with strobe 16'h0000 produces no pulse.
- rst asserted while an XRF write is pending and TRAP_DRAIN is active -> next cycle rt2xrf_valid=0, no trap_done pulse, rd_ready=0 in the reset cycle, and normal acceptance resumes after rst deasserts.

Source files
------------

// File: rtl/rvv_backend_retire_wb_if.sv
// Retire/writeback bundle: ROB retire handshake plus VRF/XRF/VCSR/trap
// outputs of the retire stage.
interface rvv_backend_retire_wb_if #(
    parameter int NUM_RT = 4,
    parameter int VLEN   = 128,
    parameter int VLENB  = VLEN / 8,
    parameter int XLEN   = 32
);
    logic [NUM_RT-1:0]       rd_valid_rob2rt;
    logic [NUM_RT-1:0]       rd_ready_rt2rob;
    logic [NUM_RT-1:0]       rt_w_valid;
    logic [NUM_RT-1:0]       rt_w_type;
    logic [NUM_RT*5-1:0]     rt_w_index;
    logic [NUM_RT*VLEN-1:0]  rt_w_data;
    logic [NUM_RT*VLENB-1:0] rt_vd_strobe;
    logic [NUM_RT*VLENB-1:0] rt_vsaturate;
    logic [NUM_RT-1:0]       rt_trap_flag;

    logic [NUM_RT-1:0]       rt2vrf_wr_valid;
    logic [NUM_RT*5-1:0]     rt2vrf_wr_index;
    logic [NUM_RT*VLEN-1:0]  rt2vrf_wr_data;
    logic [NUM_RT*VLENB-1:0] rt2vrf_wr_strobe;

    logic                    rt2xrf_valid;
    logic [4:0]              rt2xrf_index;
    logic [XLEN-1:0]         rt2xrf_data;
    logic                    xrf_ready_xrf2rt;

    logic                    rt2vcsr_vxsat_valid;
    logic                    trap_done_rvv2rvs;

    modport master (
        output rd_valid_rob2rt, rt_w_valid, rt_w_type, rt_w_index,
        output rt_w_data, rt_vd_strobe, rt_vsaturate, rt_trap_flag,
        output xrf_ready_xrf2rt,
        input  rd_ready_rt2rob,
        input  rt2vrf_wr_valid, rt2vrf_wr_index, rt2vrf_wr_data,
        input  rt2vrf_wr_strobe,
        input  rt2xrf_valid, rt2xrf_index, rt2xrf_data,
        input  rt2vcsr_vxsat_valid, trap_done_rvv2rvs
    );

    modport slave (
        input  rd_valid_rob2rt, rt_w_valid, rt_w_type, rt_w_index,
        input  rt_w_data, rt_vd_strobe, rt_vsaturate, rt_trap_flag,
        input  xrf_ready_xrf2rt,
        output rd_ready_rt2rob,
        output rt2vrf_wr_valid, rt2vrf_wr_index, rt2vrf_wr_data,
        output rt2vrf_wr_strobe,
        output rt2xrf_valid, rt2xrf_index, rt2xrf_data,
        output rt2vcsr_vxsat_valid, trap_done_rvv2rvs
    );
endinterface

// File: rtl/rvv_backend_retire_wb.sv
// Vector retire/writeback stage: in-order lane accept, same-cycle byte
// overlap resolution, VRF/XRF/vxsat registration and trap drain.
module rvv_backend_retire_wb #(
    parameter int NUM_RT = 4,
    parameter int VLEN   = 128,
    parameter int VLENB  = VLEN / 8,
    parameter int XLEN   = 32
) (
    input logic                    clk,
    input logic                    rst,
    rvv_backend_retire_wb_if.slave bus
);

    typedef enum logic {IDLE, TRAP_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic                    done_q, done_d;

    logic [NUM_RT-1:0]       vrf_vld_q, vrf_vld_d;
    logic [NUM_RT*5-1:0]     vrf_idx_q, vrf_idx_d;
    logic [NUM_RT*VLEN-1:0]  vrf_data_q, vrf_data_d;
    logic [NUM_RT*VLENB-1:0] vrf_stb_q, vrf_stb_d;

    logic                    xrf_vld_q, xrf_vld_d;
    logic [4:0]              xrf_idx_q, xrf_idx_d;
    logic [XLEN-1:0]         xrf_data_q, xrf_data_d;

    logic                    vxsat_q, vxsat_d;

    logic [NUM_RT-1:0]       acc;
    logic [NUM_RT-1:0]       vrf_we;
    logic [NUM_RT-1:0]       xrf_we;
    logic                    xrf_room;
    logic                    run;
    logic                    prev;
    logic                    trap_seen;
    logic                    xrf_seen;
    logic                    trap_acc;
    logic [VLENB-1:0]        mask;

    assign xrf_room = ~xrf_vld_q | bus.xrf_ready_xrf2rt;
    assign run      = ~rst & (state_q == IDLE);

    // Lane i only sees older lanes, so the accepted set is always a prefix.
    always_comb begin
        acc       = '0;
        prev      = 1'b1;
        trap_seen = 1'b0;
        xrf_seen  = 1'b0;
        for (int i = 0; i < NUM_RT; i++) begin
            acc[i] = bus.rd_valid_rob2rt[i] & prev & run & ~trap_seen &
                     (~(bus.rt_w_valid[i] & bus.rt_w_type[i]) |
                      (~xrf_seen & xrf_room));
            prev      = acc[i];
            trap_seen = trap_seen | (acc[i] & bus.rt_trap_flag[i]);
            xrf_seen  = xrf_seen |
                        (acc[i] & bus.rt_w_valid[i] & bus.rt_w_type[i]);
        end
    end

    always_comb begin
        vrf_we   = '0;
        xrf_we   = '0;
        trap_acc = 1'b0;
        vxsat_d  = 1'b0;
        for (int i = 0; i < NUM_RT; i++) begin
            vrf_we[i] = acc[i] & bus.rt_w_valid[i] & ~bus.rt_w_type[i] &
                        ~bus.rt_trap_flag[i];
            xrf_we[i] = acc[i] & bus.rt_w_valid[i] & bus.rt_w_type[i] &
                        ~bus.rt_trap_flag[i];
            trap_acc  = trap_acc | (acc[i] & bus.rt_trap_flag[i]);
            if (acc[i] && bus.rt_w_valid[i] && !bus.rt_trap_flag[i] &&
                |(bus.rt_vsaturate[i*VLENB +: VLENB] &
                  bus.rt_vd_strobe[i*VLENB +: VLENB]))
                vxsat_d = 1'b1;
        end
    end

    // Younger lanes to the same register claim their bytes from older ones.
    always_comb begin
        vrf_vld_d  = vrf_we;
        vrf_idx_d  = bus.rt_w_index;
        vrf_data_d = bus.rt_w_data;
        vrf_stb_d  = '0;
        mask       = '0;
        for (int i = 0; i < NUM_RT; i++) begin
            mask = '0;
            for (int j = 0; j < NUM_RT; j++) begin
                if (j > i && vrf_we[j] &&
                    bus.rt_w_index[j*5 +: 5] == bus.rt_w_index[i*5 +: 5])
                    mask = mask | bus.rt_vd_strobe[j*VLENB +: VLENB];
            end
            vrf_stb_d[i*VLENB +: VLENB] =
                bus.rt_vd_strobe[i*VLENB +: VLENB] & ~mask;
        end
    end

    always_comb begin
        xrf_vld_d  = xrf_vld_q;
        xrf_idx_d  = xrf_idx_q;
        xrf_data_d = xrf_data_q;
        if (xrf_vld_q && bus.xrf_ready_xrf2rt)
            xrf_vld_d = 1'b0;
        for (int i = 0; i < NUM_RT; i++) begin
            if (xrf_we[i]) begin
                xrf_vld_d  = 1'b1;
                xrf_idx_d  = bus.rt_w_index[i*5 +: 5];
                xrf_data_d = bus.rt_w_data[i*VLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trap_acc)
                    state_d = TRAP_DRAIN;
            end
            TRAP_DRAIN: begin
                if (xrf_room) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            vrf_vld_q  <= '0;
            vrf_idx_q  <= '0;
            vrf_data_q <= '0;
            vrf_stb_q  <= '0;
            xrf_vld_q  <= 1'b0;
            xrf_idx_q  <= '0;
            xrf_data_q <= '0;
            vxsat_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            vrf_vld_q  <= vrf_vld_d;
            vrf_idx_q  <= vrf_idx_d;
            vrf_data_q <= vrf_data_d;
            vrf_stb_q  <= vrf_stb_d;
            xrf_vld_q  <= xrf_vld_d;
            xrf_idx_q  <= xrf_idx_d;
            xrf_data_q <= xrf_data_d;
            vxsat_q    <= vxsat_d;
        end
    end

    assign bus.rd_ready_rt2rob     = acc;
    assign bus.rt2vrf_wr_valid     = vrf_vld_q;
    assign bus.rt2vrf_wr_index     = vrf_idx_q;
    assign bus.rt2vrf_wr_data      = vrf_data_q;
    assign bus.rt2vrf_wr_strobe    = vrf_stb_q;
    assign bus.rt2xrf_valid        = xrf_vld_q;
    assign bus.rt2xrf_index        = xrf_idx_q;
    assign bus.rt2xrf_data         = xrf_data_q;
    assign bus.rt2vcsr_vxsat_valid = vxsat_q;
    assign bus.trap_done_rvv2rvs   = done_q;

    a_ready_prefix: assert property (@(posedge clk) disable iff (rst)
        ((acc >> 1) & ~acc) == '0);

    a_xrf_stable: assert property (@(posedge clk) disable iff (rst)
        (xrf_vld_q && !bus.xrf_ready_xrf2rt) |=>
        ($stable(xrf_data_q) && $stable(xrf_idx_q)));

endmodule

// File: tb/tb_rvv_backend_retire_wb.sv
// Directed bench for rvv_backend_retire_wb: accept rule, overlap strobes,
// XRF hold, trap drain, vxsat and mid-operation reset.
module tb_rvv_backend_retire_wb;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   fails;

    rvv_backend_retire_wb_if bus ();

    rvv_backend_retire_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.rd_valid_rob2rt = '0;
        bus.rt_w_valid      = '0;
        bus.rt_w_type       = '0;
        bus.rt_w_index      = '0;
        bus.rt_w_data       = '0;
        bus.rt_vd_strobe    = '0;
        bus.rt_vsaturate    = '0;
        bus.rt_trap_flag    = '0;
    endtask

    task automatic lane(input int i, input bit wv, input bit wt,
                        input logic [4:0] idx, input logic [127:0] d,
                        input logic [15:0] stb, input logic [15:0] sat,
                        input bit trap);
        bus.rd_valid_rob2rt[i]      = 1'b1;
        bus.rt_w_valid[i]           = wv;
        bus.rt_w_type[i]            = wt;
        bus.rt_w_index[i*5 +: 5]    = idx;
        bus.rt_w_data[i*128 +: 128] = d;
        bus.rt_vd_strobe[i*16 +: 16] = stb;
        bus.rt_vsaturate[i*16 +: 16] = sat;
        bus.rt_trap_flag[i]         = trap;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        clr();
        bus.xrf_ready_xrf2rt = 1'b0;
        rst = 1'b1;
        bus.rd_valid_rob2rt = 4'b1111;
        tick();
        tick();
        chk("rst_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h0);
        chk("rst_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'h0);
        chk("rst_xrf_valid", 512'(bus.rt2xrf_valid), 512'h0);
        chk("rst_vxsat", 512'(bus.rt2vcsr_vxsat_valid), 512'h0);
        chk("rst_trap_done", 512'(bus.trap_done_rvv2rvs), 512'h0);
        chk("rst_strobe", 512'(bus.rt2vrf_wr_strobe), 512'h0);
        clr();
        rst = 1'b0;

        // four full-strobe VRF writes
        lane(0, 1, 0, 5'd1, {4{32'hC0DE0001}}, 16'hFFFF, 16'h0, 0);
        lane(1, 1, 0, 5'd2, {4{32'hC0DE0002}}, 16'hFFFF, 16'h0, 0);
        lane(2, 1, 0, 5'd3, {4{32'hC0DE0003}}, 16'hFFFF, 16'h0, 0);
        lane(3, 1, 0, 5'd4, {4{32'hC0DE0004}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("vrf4_rd_ready", 512'(bus.rd_ready_rt2rob), 512'hF);
        tick();
        clr();
        chk("vrf4_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'hF);
        chk("vrf4_wr_index", 512'(bus.rt2vrf_wr_index),
            512'({5'd4, 5'd3, 5'd2, 5'd1}));
        chk("vrf4_wr_data", 512'(bus.rt2vrf_wr_data),
            {{4{32'hC0DE0004}}, {4{32'hC0DE0003}},
             {4{32'hC0DE0002}}, {4{32'hC0DE0001}}});
        chk("vrf4_wr_strobe", 512'(bus.rt2vrf_wr_strobe), 512'hFFFF_FFFF_FFFF_FFFF);

        // same-index byte overlap, younger lane wins
        lane(0, 1, 0, 5'd5, {4{32'h11111111}}, 16'h00FF, 16'h0, 0);
        lane(1, 1, 0, 5'd5, {4{32'h22222222}}, 16'h0FF0, 16'h0, 0);
        #1;
        chk("ovl_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        clr();
        chk("ovl_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'h3);
        chk("ovl_strobe", 512'(bus.rt2vrf_wr_strobe[31:0]), 512'h0FF0_000F);
        chk("ovl_vxsat", 512'(bus.rt2vcsr_vxsat_valid), 512'h0);

        // two XRF writes in one group: only the first is taken
        bus.xrf_ready_xrf2rt = 1'b1;
        lane(0, 1, 1, 5'd7, {96'h0, 32'hAAAA0001}, 16'h0, 16'h0, 0);
        lane(1, 1, 0, 5'd8, {4{32'h88888888}}, 16'hFFFF, 16'h0, 0);
        lane(2, 1, 1, 5'd9, {96'h0, 32'hBBBB0002}, 16'h0, 16'h0, 0);
        lane(3, 1, 0, 5'd10, {4{32'h99999999}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("xrf_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        clr();
        chk("xrf_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'h2);
        chk("xrf_valid_a", 512'(bus.rt2xrf_valid), 512'h1);
        chk("xrf_index_a", 512'(bus.rt2xrf_index), 512'd7);
        chk("xrf_data_a", 512'(bus.rt2xrf_data), 512'hAAAA0001);
        lane(0, 1, 1, 5'd9, {96'h0, 32'hBBBB0002}, 16'h0, 16'h0, 0);
        lane(1, 1, 0, 5'd10, {4{32'h99999999}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("xrf2_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        clr();
        chk("xrf_index_b", 512'(bus.rt2xrf_index), 512'd9);
        chk("xrf_data_b", 512'(bus.rt2xrf_data), 512'hBBBB0002);

        // backpressure: pending write holds, new XRF lane is refused
        bus.xrf_ready_xrf2rt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            lane(0, 1, 1, 5'd11, {96'h0, 32'hCCCC0003}, 16'h0, 16'h0, 0);
            lane(1, 1, 0, 5'd12, {4{32'h77777777}}, 16'hFFFF, 16'h0, 0);
            #1;
            chk("hold_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h0);
            tick();
            clr();
            chk("hold_valid", 512'(bus.rt2xrf_valid), 512'h1);
            chk("hold_data", 512'(bus.rt2xrf_data), 512'hBBBB0002);
            chk("hold_index", 512'(bus.rt2xrf_index), 512'd9);
        end
        bus.xrf_ready_xrf2rt = 1'b1;
        lane(0, 1, 1, 5'd11, {96'h0, 32'hCCCC0003}, 16'h0, 16'h0, 0);
        lane(1, 1, 0, 5'd12, {4{32'h77777777}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("reload_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        clr();
        chk("reload_valid", 512'(bus.rt2xrf_valid), 512'h1);
        chk("reload_data", 512'(bus.rt2xrf_data), 512'hCCCC0003);
        tick();
        chk("drain_valid", 512'(bus.rt2xrf_valid), 512'h0);
        bus.xrf_ready_xrf2rt = 1'b0;

        // trap on lane 1
        lane(0, 1, 0, 5'd1, {4{32'h01010101}}, 16'hFFFF, 16'h0, 0);
        lane(1, 1, 0, 5'd2, {4{32'h02020202}}, 16'hFFFF, 16'hFFFF, 1);
        lane(2, 1, 0, 5'd3, {4{32'h03030303}}, 16'hFFFF, 16'h0, 0);
        lane(3, 1, 0, 5'd4, {4{32'h04040404}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("trap_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        chk("trap_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'h1);
        chk("trap_vxsat", 512'(bus.rt2vcsr_vxsat_valid), 512'h0);
        chk("trap_drain_ready", 512'(bus.rd_ready_rt2rob), 512'h0);
        chk("trap_done_early", 512'(bus.trap_done_rvv2rvs), 512'h0);
        clr();
        tick();
        chk("trap_done_pulse", 512'(bus.trap_done_rvv2rvs), 512'h1);
        tick();
        chk("trap_done_clear", 512'(bus.trap_done_rvv2rvs), 512'h0);

        // vxsat from lane 2, then masked by a zero strobe
        lane(0, 1, 0, 5'd1, {4{32'h0}}, 16'hFFFF, 16'h0, 0);
        lane(1, 1, 0, 5'd2, {4{32'h0}}, 16'hFFFF, 16'h0, 0);
        lane(2, 1, 0, 5'd3, {4{32'h0}}, 16'h0001, 16'h0001, 0);
        tick();
        clr();
        chk("vxsat_pulse", 512'(bus.rt2vcsr_vxsat_valid), 512'h1);
        tick();
        chk("vxsat_one_cycle", 512'(bus.rt2vcsr_vxsat_valid), 512'h0);
        lane(0, 1, 0, 5'd1, {4{32'h0}}, 16'hFFFF, 16'h0, 0);
        lane(1, 1, 0, 5'd2, {4{32'h0}}, 16'hFFFF, 16'h0, 0);
        lane(2, 1, 0, 5'd3, {4{32'h0}}, 16'h0000, 16'h0001, 0);
        tick();
        clr();
        chk("vxsat_masked", 512'(bus.rt2vcsr_vxsat_valid), 512'h0);
        chk("zero_stb_valid", 512'(bus.rt2vrf_wr_valid), 512'h7);
        chk("zero_stb_lane2", 512'(bus.rt2vrf_wr_strobe[47:32]), 512'h0);

        // reset during pending XRF write and trap drain
        lane(0, 1, 1, 5'd12, {96'h0, 32'hDDDD0004}, 16'h0, 16'h0, 0);
        lane(1, 1, 0, 5'd13, {4{32'h0}}, 16'hFFFF, 16'h0, 1);
        #1;
        chk("rstmid_rd_ready", 512'(bus.rd_ready_rt2rob), 512'h3);
        tick();
        clr();
        chk("rstmid_xrf_valid", 512'(bus.rt2xrf_valid), 512'h1);
        tick();
        chk("rstmid_stuck", 512'(bus.trap_done_rvv2rvs), 512'h0);
        rst = 1'b1;
        lane(0, 1, 0, 5'd6, {4{32'h66666666}}, 16'hFFFF, 16'h0, 0);
        #1;
        chk("rstmid_ready_in_rst", 512'(bus.rd_ready_rt2rob), 512'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_xrf_cleared", 512'(bus.rt2xrf_valid), 512'h0);
        chk("rstmid_no_done", 512'(bus.trap_done_rvv2rvs), 512'h0);
        chk("rstmid_wr_valid", 512'(bus.rt2vrf_wr_valid), 512'h0);
        chk("rstmid_resume", 512'(bus.rd_ready_rt2rob), 512'h1);
        tick();
        clr();
        chk("rstmid_resume_wr", 512'(bus.rt2vrf_wr_valid), 512'h1);
        chk("rstmid_resume_idx", 512'(bus.rt2vrf_wr_index[4:0]), 512'd6);
        chk("rstmid_no_late_done", 512'(bus.trap_done_rvv2rvs), 512'h0);
        tick();
        chk("rstmid_no_done2", 512'(bus.trap_done_rvv2rvs), 512'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
